// File: rtl/io_bus_arbiter_pkg.sv
// Shared constants for the IODevices port arbiter: sequencer state encoding,
// device ids and a small index-width helper.
package io_bus_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_GRANT = ST_GRANT,
    S_EXEC  = ST_EXEC,
    S_DONE  = ST_DONE
  } arb_state_e;

  localparam logic [7:0] DEV_NONE  = 8'd0;
  localparam logic [7:0] DEV_INPUT = 8'd1;
  localparam logic [7:0] DEV_PROM  = 8'd2;
  localparam logic [7:0] DEV_CONST = 8'd3;
  localparam logic [7:0] DEV_IPC   = 8'd5;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Requester-side req/done signals plus the IODevices port, bundled for the arbiter.
// Handshake: a requester raises req with stable operands and holds them until it
// sees its one-cycle done pulse; gnt marks the owner for the whole transaction.
interface io_bus_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DEV_W   = 8,
  parameter int DATA_W  = 32
) ();

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*DEV_W-1:0]  req_device_id;
  logic [NUM_REQ*DATA_W-1:0] req_value;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rdata;
  logic                      err;
  logic                      busy;
  logic [DEV_W-1:0]          io_device_id;
  logic [DATA_W-1:0]         io_value_in;
  logic                      io_is_write;
  logic [DATA_W-1:0]         io_value_out;
  logic [1:0]                dbg_state;

  modport slave (
    input  req, req_write, req_device_id, req_value, io_value_out,
    output gnt, done, rdata, err, busy, io_device_id, io_value_in, io_is_write, dbg_state
  );

  modport master (
    output req, req_write, req_device_id, req_value, io_value_out,
    input  gnt, done, rdata, err, busy, io_device_id, io_value_in, io_is_write, dbg_state
  );

endinterface

// File: rtl/io_rr_picker.sv
// Combinational requester picker: round-robin search starting after ptr_i, or
// lowest-index-wins when IO_ARB_FIXED_PRIO_EN is defined (ptr_i then ignored).
module io_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] pick_oh_o,
  output logic [IDX_W-1:0]   pick_idx_o,
  output logic               any_o
);

`ifdef IO_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  always_comb begin
    pick_oh_o  = '0;
    pick_idx_o = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        pick_oh_o    = '0;
        pick_oh_o[i] = 1'b1;
        pick_idx_o   = IDX_W'(i);
      end
    end
  end
`else
  // Scan from farthest to nearest so the candidate closest after ptr_i wins.
  always_comb begin
    pick_oh_o  = '0;
    pick_idx_o = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      int j;
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (req_i[j[IDX_W-1:0]]) begin
        pick_oh_o                 = '0;
        pick_oh_o[j[IDX_W-1:0]]   = 1'b1;
        pick_idx_o                = j[IDX_W-1:0];
      end
    end
  end
`endif

  assign any_o = |req_i;

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares one IODevices port between NUM_REQ requesters with a 4-state sequencer.
// Define IO_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DEV_W   = 8,
  parameter int DATA_W  = 32
) (
  input logic            clk,
  input logic            reset,
  io_bus_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                wr_q, wr_d;
  logic [DEV_W-1:0]    dev_q, dev_d;
  logic [DATA_W-1:0]   val_q, val_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                no_dev;

  logic [NUM_REQ-1:0]  pick_oh;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    pick_ptr;
  logic                pick_any;

`ifdef IO_ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  assign pick_ptr = ptr_q;
`endif

  io_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i      (bus.req),
    .ptr_i      (pick_ptr),
    .pick_oh_o  (pick_oh),
    .pick_idx_o (pick_idx),
    .any_o      (pick_any)
  );

  assign no_dev = (dev_q == DEV_W'(DEV_NONE));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    dev_d   = dev_q;
    val_d   = val_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifndef IO_ARB_FIXED_PRIO_EN
    idx_d   = idx_q;
    ptr_d   = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Operands are captured here; later requester changes cannot leak in.
        if (pick_any) begin
          state_d = S_GRANT;
          gnt_d   = pick_oh;
          wr_d    = bus.req_write[pick_idx];
          dev_d   = bus.req_device_id[pick_idx*DEV_W +: DEV_W];
          val_d   = bus.req_value[pick_idx*DATA_W +: DATA_W];
`ifndef IO_ARB_FIXED_PRIO_EN
          idx_d   = pick_idx;
`endif
        end
      end
      S_GRANT: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_DONE;
        if (no_dev) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end else if (!wr_q) begin
          rdata_d = bus.io_value_out;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
`ifndef IO_ARB_FIXED_PRIO_EN
        ptr_d   = idx_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      dev_q   <= '0;
      val_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifndef IO_ARB_FIXED_PRIO_EN
      idx_q   <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      dev_q   <= dev_d;
      val_q   <= val_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifndef IO_ARB_FIXED_PRIO_EN
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
`endif
    end
  end

  // io_is_write decodes straight from state so an async reset drops it at once.
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.gnt          = bus.busy ? gnt_q : '0;
  assign bus.done         = (state_q == S_DONE) ? gnt_q : '0;
  assign bus.io_device_id = bus.busy ? dev_q : '0;
  assign bus.io_value_in  = bus.busy ? val_q : '0;
  assign bus.io_is_write  = (state_q == S_EXEC) && wr_q && !no_dev;
  assign bus.rdata        = rdata_q;
  assign bus.err          = err_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Randomized and directed bench for io_bus_arbiter against a transaction-level
// model (arbitration order, device contents, expected bus writes).
module tb_io_bus_arbiter;
  import io_bus_pkg::*;

  localparam int NR = 3;
  localparam int DW = 8;
  localparam int XW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  io_bus_arbiter_if #(.NUM_REQ(NR), .DEV_W(DW), .DATA_W(XW)) bus ();

  io_bus_arbiter #(.NUM_REQ(NR), .DEV_W(DW), .DATA_W(XW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- IODevices environment ----------------
  logic [XW-1:0]     dev_mem [256];
  logic [255:0]      dev_wr_valid = '0;
  logic [DW+XW-1:0]  act_q[$];

  always_comb begin
    if (bus.io_device_id == DEV_CONST)      bus.io_value_out = 32'hE5F84AB1;
    else if (dev_wr_valid[bus.io_device_id]) bus.io_value_out = dev_mem[bus.io_device_id];
    else                                     bus.io_value_out = {4{bus.io_device_id}} ^ 32'h5A5A_0000;
  end

  always @(posedge clk) begin
    if (bus.io_is_write) begin
      act_q.push_back({bus.io_device_id, bus.io_value_in});
      dev_mem[bus.io_device_id]      <= bus.io_value_in;
      dev_wr_valid[bus.io_device_id] <= 1'b1;
    end
  end

  // ---------------- reference model ----------------
  logic [NR-1:0] m_req;
  logic          op_wr  [NR];
  logic [DW-1:0] op_dev [NR];
  logic [XW-1:0] op_val [NR];
  int            last_win;
  logic [XW-1:0] m_rdata;
  logic [XW-1:0] m_mem [int];
  logic [DW-1:0] devs [5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5};

  function automatic int pick(input logic [NR-1:0] r);
`ifdef IO_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NR; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= NR; k++) if (r[(last_win + k) % NR]) return (last_win + k) % NR;
`endif
    return -1;
  endfunction

  function automatic logic [XW-1:0] model_read(input logic [DW-1:0] dev);
    if (dev == DEV_CONST) return 32'hE5F84AB1;
    if (m_mem.exists(int'(dev))) return m_mem[int'(dev)];
    return {4{dev}} ^ 32'h5A5A_0000;
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req[i]                  = m_req[i];
      bus.req_write[i]            = op_wr[i];
      bus.req_device_id[i*DW +: DW] = op_dev[i];
      bus.req_value[i*XW +: XW]   = op_val[i];
    end
  endtask

  task automatic model_reset();
    last_win = NR - 1;
    m_rdata  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_req = '0;
    drive();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  // Called at an idle negedge with requests already driven; ends at the next idle negedge.
  task automatic run_txn(input string tag, input bit drop, input bit chg_dev);
    int w, n, wcnt, bad;
    logic          wr;
    logic [DW-1:0] dev;
    logic [XW-1:0] val, exp_rd;
    logic [NR-1:0] w_oh, dn;
    logic [DW+XW-1:0] got_w;
    w = pick(m_req);
    if (w < 0) return;
    wr = op_wr[w]; dev = op_dev[w]; val = op_val[w];
    w_oh = '0; w_oh[w] = 1'b1;
    n = 0; wcnt = 0; bad = 0; dn = '0;
    while (dn == '0 && n < 8) begin
      @(negedge clk);
      n++;
      if (chg_dev && n == 1) begin
        op_dev[0] = DEV_CONST;
        drive();
      end
      if (bus.io_is_write) wcnt++;
      if (bus.gnt !== w_oh || bus.io_device_id !== dev) bad++;
      if (n == 2) begin
        check_eq({tag, ":exec_is_write"}, 64'(bus.io_is_write), 64'(wr && dev != '0));
        if (wr && dev != '0) check_eq({tag, ":exec_value_in"}, 64'(bus.io_value_in), 64'(val));
      end
      dn = bus.done;
    end
    check_eq({tag, ":latency"}, 64'(n), 64'd3);
    check_eq({tag, ":done"}, 64'(dn), 64'(w_oh));
    check_eq({tag, ":err"}, 64'(bus.err), 64'(dev == '0));
    if (dev == '0)  exp_rd = '0;
    else if (!wr)   exp_rd = model_read(dev);
    else            exp_rd = m_rdata;
    m_rdata = exp_rd;
    check_eq({tag, ":rdata"}, 64'(bus.rdata), 64'(exp_rd));
    check_eq({tag, ":bus_hold_bad_cycles"}, 64'(bad), 64'd0);
    check_eq({tag, ":is_write_cycles"}, 64'(wcnt), 64'(wr && dev != '0));
    if (wr && dev != '0) begin
      check_eq({tag, ":commits"}, 64'(act_q.size()), 64'd1);
      if (act_q.size() > 0) begin
        got_w = act_q.pop_front();
        check_eq({tag, ":commit_data"}, 64'(got_w), 64'({dev, val}));
      end
      m_mem[int'(dev)] = val;
    end else begin
      check_eq({tag, ":commits"}, 64'(act_q.size()), 64'd0);
    end
    last_win = w;
    if (drop) begin
      m_req[w] = 1'b0;
      drive();
    end
    @(negedge clk);
    check_eq({tag, ":idle_busy"}, 64'(bus.busy), 64'd0);
    check_eq({tag, ":idle_err"}, 64'(bus.err), 64'd0);
    check_eq({tag, ":idle_rdata"}, 64'(bus.rdata), 64'(m_rdata));
  endtask

  task automatic set_op(input int i, input logic wr, input logic [DW-1:0] dev, input logic [XW-1:0] val);
    op_wr[i] = wr; op_dev[i] = dev; op_val[i] = val; m_req[i] = 1'b1;
    drive();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    m_req = '0;
    for (int i = 0; i < NR; i++) begin
      op_wr[i] = 1'b0; op_dev[i] = '0; op_val[i] = '0;
    end
    drive();
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst:gnt", 64'(bus.gnt), 64'd0);
    check_eq("rst:done", 64'(bus.done), 64'd0);
    check_eq("rst:rdata", 64'(bus.rdata), 64'd0);
    check_eq("rst:err", 64'(bus.err), 64'd0);
    check_eq("rst:busy", 64'(bus.busy), 64'd0);
    check_eq("rst:io_device_id", 64'(bus.io_device_id), 64'd0);
    check_eq("rst:io_value_in", 64'(bus.io_value_in), 64'd0);
    check_eq("rst:io_is_write", 64'(bus.io_is_write), 64'd0);
    check_eq("rst:state", 64'(bus.dbg_state), 64'(ST_IDLE));
    reset = 1'b0;
    @(negedge clk);

    set_op(0, 1'b0, DEV_CONST, '0);
    run_txn("single_read", 1'b1, 1'b0);
    set_op(1, 1'b1, DEV_IPC, 32'd10);
    run_txn("single_write", 1'b1, 1'b0);
    set_op(0, 1'b0, DEV_IPC, '0);
    run_txn("readback_ipc", 1'b1, 1'b0);
    set_op(0, 1'b0, DEV_NONE, '0);
    run_txn("no_device_read", 1'b1, 1'b0);
    set_op(2, 1'b1, DEV_NONE, 32'h1234);
    run_txn("no_device_write", 1'b1, 1'b0);
    set_op(0, 1'b0, DEV_PROM, '0);
    run_txn("operand_change", 1'b1, 1'b1);

    do_reset();
    set_op(0, 1'b0, DEV_CONST, '0);
    set_op(1, 1'b0, DEV_PROM, '0);
    for (int t = 0; t < 4; t++) run_txn($sformatf("contention%0d", t), 1'b0, 1'b0);
    m_req = '0;
    drive();
    @(negedge clk);

    set_op(1, 1'b1, DEV_IPC, 32'd7);
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_exec:is_write_before", 64'(bus.io_is_write), 64'd1);
    #1 reset = 1'b1;
    #1;
    check_eq("rst_exec:is_write", 64'(bus.io_is_write), 64'd0);
    check_eq("rst_exec:busy", 64'(bus.busy), 64'd0);
    check_eq("rst_exec:gnt", 64'(bus.gnt), 64'd0);
    check_eq("rst_exec:io_device_id", 64'(bus.io_device_id), 64'd0);
    check_eq("rst_exec:io_value_in", 64'(bus.io_value_in), 64'd0);
    check_eq("rst_exec:state", 64'(bus.dbg_state), 64'(ST_IDLE));
    m_req = '0;
    drive();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_eq("rst_exec:commits", 64'(act_q.size()), 64'd0);
    check_eq("rst_exec:rdata", 64'(bus.rdata), 64'd0);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NR; i++) begin
        if (!m_req[i] && $urandom_range(0, 1) == 1)
          set_op(i, 1'($urandom_range(0, 1)), devs[$urandom_range(0, 4)], $urandom);
      end
      if (m_req == '0) set_op(int'($urandom_range(0, NR - 1)), 1'b0, devs[$urandom_range(0, 4)], '0);
      if ($countones(m_req) > 1 && $urandom_range(0, 5) == 0) begin
        for (int i = 0; i < NR; i++) begin
          if (m_req[i]) begin
            m_req[i] = 1'b0;
            break;
          end
        end
        drive();
      end
      run_txn($sformatf("rand%0d", t), 1'($urandom_range(0, 3) != 0), 1'b0);
    end
    m_req = '0;
    drive();
    repeat (2) @(negedge clk);
    check_eq("final:leftover_commits", 64'(act_q.size()), 64'd0);
    check_eq("final:busy", 64'(bus.busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
